// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state/cause encodings and counter sizing for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_BTN = 2'b01,
        CAUSE_SW  = 2'b10
    } cause_t;

    localparam int COUNT_W = 8;

    // Width able to hold the largest of three cycle counts, never narrower than one bit
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises the raw button, normalises it to pressed=1 and debounces it
module btn_debounce
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_pressed
);

    localparam int   DW   = cnt_width(DEBOUNCE_CYCLES, 0, 0);
    localparam logic IDLE = (BTN_ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic                   db;
    logic [DW-1:0]          cnt;

    assign synced    = sync[SYNC_STAGES-1] ^ IDLE;
    assign o_pressed = (DEBOUNCE_CYCLES == 0) ? synced : db;

    // Shift the raw pin through the synchroniser; reset to the released pin level
    always_ff @(posedge clock)
        if (reset)
            sync <= {SYNC_STAGES{IDLE}};
        else
            sync <= {sync[SYNC_STAGES-2:0], i_btn};

    // Flip the debounced level only after a full run of disagreeing samples
    always_ff @(posedge clock)
        if (reset) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (synced == db)
            cnt <= '0;
        else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            db  <= synced;
            cnt <= '0;
        end else
            cnt <= cnt + 1'b1;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all reset domains while a reset source is active, then releases them in staggered order
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_OUT         = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_btn,
    input  logic               i_sw_reset,
    output logic [NUM_OUT-1:0] o_reset,
    output logic               o_ready,
    output logic [1:0]         o_cause,
    output logic [7:0]         o_reset_count
);

    localparam int                 CW  = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES);
    localparam int                 IW  = $clog2(NUM_OUT + 1);
    localparam logic [NUM_OUT-1:0] ONE = NUM_OUT'(1);

    state_t               state, state_d;
    cause_t               cause, cause_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [IW-1:0]        idx, idx_d;
    logic [NUM_OUT-1:0]   reset_d;
    logic                 ready_d;
    logic [COUNT_W-1:0]   count_d;
    logic                 pressed;
    logic                 src;
    logic                 hold_done;
    logic                 stage_done;
    logic                 last;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clock    (clock),
        .reset    (reset),
        .i_btn    (i_btn),
        .o_pressed(pressed)
    );

    assign src        = pressed | i_sw_reset;
    assign hold_done  = cnt == CW'(HOLD_CYCLES - 1);
    assign stage_done = cnt == CW'(STAGGER_CYCLES - 1);
    assign last       = idx == IW'(NUM_OUT - 1);
    assign o_cause    = cause;

    // State register
    always_ff @(posedge clock)
        if (reset)
            state <= HOLD;
        else
            state <= state_d;

    // Next state: any reset source overrides every other transition
    always_comb
        state_d = src                                      ? HOLD    :
                  (state == HOLD && hold_done)             ? RELEASE :
                  (state == RELEASE && stage_done && last) ? RUN     : state;

    // Next counters and outputs; a held button keeps the same cause and is counted once
    always_comb begin
        cnt_d   = '0;
        idx_d   = idx;
        reset_d = o_reset;
        ready_d = o_ready;
        cause_d = cause;
        count_d = o_reset_count;
        if (src) begin
            idx_d   = '0;
            reset_d = '1;
            ready_d = 1'b0;
            cause_d = pressed ? CAUSE_BTN : CAUSE_SW;
            if ((state != HOLD || cause_d != cause) && o_reset_count != '1)
                count_d = o_reset_count + 1'b1;
        end else if (state == HOLD)
            cnt_d = hold_done ? '0 : cnt + 1'b1;
        else if (state == RELEASE) begin
            cnt_d = stage_done ? '0 : cnt + 1'b1;
            if (stage_done) begin
                reset_d = o_reset & ~(ONE << idx);
                idx_d   = idx + 1'b1;
                ready_d = last;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock)
        if (reset) begin
            cnt           <= '0;
            idx           <= '0;
            o_reset       <= '1;
            o_ready       <= 1'b0;
            cause         <= CAUSE_POR;
            o_reset_count <= '0;
        end else begin
            cnt           <= cnt_d;
            idx           <= idx_d;
            o_reset       <= reset_d;
            o_ready       <= ready_d;
            cause         <= cause_d;
            o_reset_count <= count_d;
        end

endmodule
